// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND page-copy controller: command opcodes,
// sequencer/bus-engine state encodings and the address byte helper.
package nfc_pkg;

  localparam int PAGES_DEF      = 512;
  localparam int PAGE_BYTES_DEF = 512;
  localparam int TWB_CYC_DEF    = 8;

  localparam logic [7:0] CMD_READ    = 8'h00;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_PROG_GO = 8'h10;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_AB,
    ST_RD_CMD,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_PG_CMD,
    ST_PG_ADDR,
    ST_XFER,
    ST_PG_END,
    ST_PG_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_CMD,
    OP_ADDR,
    OP_DATA,
    OP_READ,
    OP_WAIT
  } op_t;

  typedef enum logic [3:0] {
    B_IDLE,
    B_W0,
    B_W1,
    B_W2,
    B_R0,
    B_R1,
    B_R2,
    B_TWB,
    B_RB
  } bus_state_t;

  // Address cycles go out as column (always 0), page low byte, page bit 8.
  function automatic logic [7:0] addr_byte(input logic [1:0] idx, input logic [8:0] pg);
    case (idx)
      2'd0:    addr_byte = 8'h00;
      2'd1:    addr_byte = pg[7:0];
      default: addr_byte = {7'b0, pg[8]};
    endcase
  endfunction

endpackage

// File: rtl/nand_if.sv
// Single-device NAND bus engine: runs one 3-clock write cycle, 3-clock read
// cycle or busy-wait per request and pulses ack on its final clock.
module nand_if
  import nfc_pkg::*;
#(
  parameter int TWB_CYC = TWB_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  op_t        op,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       cle,
  output logic       ale,
  output logic       ren,
  output logic       wen,
  input  logic       rb
);

  localparam int TW = $clog2(TWB_CYC + 1);

  bus_state_t    state, state_n;
  op_t           op_q;
  logic [7:0]    data_q;
  logic [TW-1:0] twb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= B_IDLE;
      op_q    <= OP_CMD;
      data_q  <= '0;
      rdata   <= '0;
      twb_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == B_IDLE && req) begin
        op_q   <= op;
        data_q <= wdata;
      end
      if (state == B_R1) rdata <= io_in;
      if (state == B_TWB) twb_cnt <= twb_cnt + 1'b1;
      else                twb_cnt <= '0;
    end
  end

  // Strobes decode straight from the state so a reset idles them in one clock.
  always_comb begin
    state_n = state;
    ack     = 1'b0;
    io_out  = data_q;
    io_oe   = 1'b0;
    cle     = 1'b0;
    ale     = 1'b0;
    ren     = 1'b1;
    wen     = 1'b1;
    case (state)
      B_IDLE: begin
        if (req) begin
          case (op)
            OP_READ: state_n = B_R0;
            OP_WAIT: state_n = B_TWB;
            default: state_n = B_W0;
          endcase
        end
      end
      B_W0, B_W1: begin
        io_oe   = 1'b1;
        cle     = (op_q == OP_CMD);
        ale     = (op_q == OP_ADDR);
        wen     = 1'b0;
        state_n = (state == B_W0) ? B_W1 : B_W2;
      end
      B_W2: begin
        io_oe   = 1'b1;
        cle     = (op_q == OP_CMD);
        ale     = (op_q == OP_ADDR);
        ack     = 1'b1;
        state_n = B_IDLE;
      end
      B_R0: begin
        ren     = 1'b0;
        state_n = B_R1;
      end
      B_R1: begin
        ren     = 1'b0;
        state_n = B_R2;
      end
      B_R2: begin
        ack     = 1'b1;
        state_n = B_IDLE;
      end
      B_TWB: begin
        if (twb_cnt == TW'(TWB_CYC - 1)) state_n = B_RB;
      end
      B_RB: begin
        if (rb) begin
          ack     = 1'b1;
          state_n = B_IDLE;
        end
      end
      default: state_n = B_IDLE;
    endcase
  end

endmodule

// File: rtl/nfc_ctrl.sv
// NAND copy controller: resets both devices, then streams every page of
// flash A into flash B one byte at a time and raises done when finished.
module nfc_ctrl
  import nfc_pkg::*;
#(
  parameter int PAGES      = PAGES_DEF,
  parameter int PAGE_BYTES = PAGE_BYTES_DEF,
  parameter int TWB_CYC    = TWB_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic       done,
  inout  wire  [7:0] F_IO_A,
  output logic       F_CLE_A,
  output logic       F_ALE_A,
  output logic       F_REN_A,
  output logic       F_WEN_A,
  input  logic       F_RB_A,
  inout  wire  [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_REN_B,
  output logic       F_WEN_B,
  input  logic       F_RB_B
);

  localparam logic [8:0] LAST_PAGE = 9'(PAGES - 1);
  localparam logic [8:0] LAST_COL  = 9'(PAGE_BYTES - 1);

  state_t     state, state_n;
  logic [1:0] step, step_n;
  logic [8:0] page, page_n;
  logic [8:0] col, col_n;
  logic [7:0] byte_q, byte_n;

  logic       req_a, req_b, ack_a, ack_b;
  op_t        op_a, op_b;
  logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [7:0] io_out_a, io_out_b;
  logic       io_oe_a, io_oe_b, ren_b;
  logic       unused_b;

  nand_if #(.TWB_CYC(TWB_CYC)) u_if_a (
    .clk(clk), .rst(rst), .req(req_a), .op(op_a), .wdata(wdata_a),
    .ack(ack_a), .rdata(rdata_a), .io_in(F_IO_A), .io_out(io_out_a),
    .io_oe(io_oe_a), .cle(F_CLE_A), .ale(F_ALE_A), .ren(F_REN_A),
    .wen(F_WEN_A), .rb(F_RB_A)
  );

  nand_if #(.TWB_CYC(TWB_CYC)) u_if_b (
    .clk(clk), .rst(rst), .req(req_b), .op(op_b), .wdata(wdata_b),
    .ack(ack_b), .rdata(rdata_b), .io_in(F_IO_B), .io_out(io_out_b),
    .io_oe(io_oe_b), .cle(F_CLE_B), .ale(F_ALE_B), .ren(ren_b),
    .wen(F_WEN_B), .rb(F_RB_B)
  );

  assign F_IO_A   = io_oe_a ? io_out_a : 8'hzz;
  assign F_IO_B   = io_oe_b ? io_out_b : 8'hzz;
  // B is only ever written, so its read strobe is tied off.
  assign F_REN_B  = 1'b1;
  assign unused_b = ^{rdata_b, ren_b};
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      step   <= '0;
      page   <= '0;
      col    <= '0;
      byte_q <= '0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      page   <= page_n;
      col    <= col_n;
      byte_q <= byte_n;
    end
  end

  // Each state holds its request until the engine acks, then advances; step
  // counts address cycles, RST_AB sub-phases, or read/write halves in XFER.
  always_comb begin
    state_n = state;
    step_n  = step;
    page_n  = page;
    col_n   = col;
    byte_n  = byte_q;
    req_a   = 1'b0;
    op_a    = OP_CMD;
    wdata_a = CMD_RESET;
    req_b   = 1'b0;
    op_b    = OP_CMD;
    wdata_b = CMD_RESET;
    case (state)
      ST_IDLE: begin
        state_n = ST_RST_AB;
        step_n  = '0;
        page_n  = '0;
        col_n   = '0;
      end
      ST_RST_AB: begin
        case (step)
          2'd0: begin
            req_a = 1'b1;
            if (ack_a) step_n = 2'd1;
          end
          2'd1: begin
            req_b = 1'b1;
            if (ack_b) step_n = 2'd2;
          end
          2'd2: begin
            req_a = 1'b1;
            op_a  = OP_WAIT;
            if (ack_a) step_n = 2'd3;
          end
          default: begin
            req_b = 1'b1;
            op_b  = OP_WAIT;
            if (ack_b) begin
              step_n  = '0;
              state_n = ST_RD_CMD;
            end
          end
        endcase
      end
      ST_RD_CMD: begin
        req_a   = 1'b1;
        wdata_a = CMD_READ;
        if (ack_a) state_n = ST_RD_ADDR;
      end
      ST_RD_ADDR: begin
        req_a   = 1'b1;
        op_a    = OP_ADDR;
        wdata_a = addr_byte(step, page);
        if (ack_a) begin
          if (step == 2'd2) begin
            step_n  = '0;
            state_n = ST_RD_WAIT;
          end else begin
            step_n = step + 2'd1;
          end
        end
      end
      ST_RD_WAIT: begin
        req_a = 1'b1;
        op_a  = OP_WAIT;
        if (ack_a) state_n = ST_PG_CMD;
      end
      ST_PG_CMD: begin
        req_b   = 1'b1;
        wdata_b = CMD_PROG;
        if (ack_b) state_n = ST_PG_ADDR;
      end
      ST_PG_ADDR: begin
        req_b   = 1'b1;
        op_b    = OP_ADDR;
        wdata_b = addr_byte(step, page);
        if (ack_b) begin
          if (step == 2'd2) begin
            step_n  = '0;
            col_n   = '0;
            state_n = ST_XFER;
          end else begin
            step_n = step + 2'd1;
          end
        end
      end
      ST_XFER: begin
        if (!step[0]) begin
          req_a = 1'b1;
          op_a  = OP_READ;
          if (ack_a) begin
            byte_n = rdata_a;
            step_n = 2'd1;
          end
        end else begin
          req_b   = 1'b1;
          op_b    = OP_DATA;
          wdata_b = byte_q;
          if (ack_b) begin
            step_n = '0;
            if (col == LAST_COL) state_n = ST_PG_END;
            else                 col_n   = col + 9'd1;
          end
        end
      end
      ST_PG_END: begin
        req_b   = 1'b1;
        wdata_b = CMD_PROG_GO;
        if (ack_b) state_n = ST_PG_WAIT;
      end
      ST_PG_WAIT: begin
        req_b = 1'b1;
        op_b  = OP_WAIT;
        if (ack_b) begin
          if (page == LAST_PAGE) begin
            state_n = ST_DONE;
          end else begin
            page_n  = page + 9'd1;
            state_n = ST_RD_CMD;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nfc_ctrl.sv
// Bench for nfc_ctrl: behavioural NAND models on both buses, a protocol
// monitor, and directed phases over a reduced geometry with random data.
module tb_nfc_ctrl;

  localparam int PAGES = 258;
  localparam int PB    = 8;
  localparam int TWB   = 8;
  localparam int N     = PAGES * PB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done;
  wire  [7:0] F_IO_A, F_IO_B;
  logic F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A, F_RB_A;
  logic F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B, F_RB_B;

  logic       probe_en  = 1'b0;
  logic [7:0] probe_val = 8'h00;

  int n_compared   = 0;
  int n_mismatched = 0;

  nfc_ctrl #(.PAGES(PAGES), .PAGE_BYTES(PB), .TWB_CYC(TWB)) dut (
    .clk(clk), .rst(rst), .done(done),
    .F_IO_A(F_IO_A), .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A),
    .F_REN_A(F_REN_A), .F_WEN_A(F_WEN_A), .F_RB_A(F_RB_A),
    .F_IO_B(F_IO_B), .F_CLE_B(F_CLE_B), .F_ALE_B(F_ALE_B),
    .F_REN_B(F_REN_B), .F_WEN_B(F_WEN_B), .F_RB_B(F_RB_B)
  );

  always #10 clk = ~clk;

  // Flash A model: latches cmd/addr on WEN rising, drives data while REN is low.
  logic [7:0]  memA [N];
  logic [7:0]  a_dout;
  logic [7:0]  a_cmd = 8'hFF;
  logic [7:0]  a_adr [3];
  int          a_nadr = 0, a_page = 0, a_col = 0, a_busy_cnt = 0;
  logic        a_wen_q = 1'b1, a_ren_q = 1'b1;
  logic [23:0] a_rd_log [$];

  assign a_dout = (a_col < PB && a_page < PAGES) ? memA[a_page*PB + a_col] : 8'hFF;
  assign F_IO_A = (probe_en || F_REN_A === 1'b0) ? (probe_en ? probe_val : a_dout) : 8'hzz;
  assign F_RB_A = (a_busy_cnt == 0);

  always @(negedge clk) begin : model_a
    a_wen_q <= F_WEN_A;
    a_ren_q <= F_REN_A;
    if (a_busy_cnt != 0) a_busy_cnt <= a_busy_cnt - 1;
    if (!a_wen_q && F_WEN_A) begin
      if (F_CLE_A) begin
        a_cmd  <= F_IO_A;
        a_nadr <= 0;
        if (F_IO_A == 8'hFF) a_busy_cnt <= int'($urandom_range(2, 6));
      end else if (F_ALE_A) begin
        if (a_nadr < 3) a_adr[a_nadr] <= F_IO_A;
        a_nadr <= a_nadr + 1;
        if (a_cmd == 8'h00 && a_nadr == 2) begin
          a_page     <= int'({F_IO_A[0], a_adr[1]});
          a_col      <= 0;
          a_busy_cnt <= int'($urandom_range(2, 6));
          a_rd_log.push_back({F_IO_A, a_adr[1], a_adr[0]});
        end
      end
    end else if (!a_ren_q && F_REN_A) begin
      a_col <= a_col + 1;
    end
  end

  // Flash B model: programs data bytes into memB at the addressed page.
  logic [7:0]  memB [N];
  logic [7:0]  b_cmd = 8'hFF;
  logic [7:0]  b_adr [3];
  int          b_nadr = 0, b_page = 0, b_col = 0, b_busy_cnt = 0;
  int          b_spare = 0, b_rst_cnt = 0;
  logic        b_wen_q = 1'b1;
  logic [23:0] b_pg_log [$];

  assign F_IO_B = probe_en ? probe_val : 8'hzz;
  assign F_RB_B = (b_busy_cnt == 0);

  always @(negedge clk) begin : model_b
    b_wen_q <= F_WEN_B;
    if (b_busy_cnt != 0) b_busy_cnt <= b_busy_cnt - 1;
    if (!b_wen_q && F_WEN_B) begin
      if (F_CLE_B) begin
        b_cmd  <= F_IO_B;
        b_nadr <= 0;
        if (F_IO_B == 8'hFF) b_rst_cnt <= b_rst_cnt + 1;
        if (F_IO_B == 8'hFF || F_IO_B == 8'h10) b_busy_cnt <= int'($urandom_range(2, 6));
      end else if (F_ALE_B) begin
        if (b_nadr < 3) b_adr[b_nadr] <= F_IO_B;
        b_nadr <= b_nadr + 1;
        if (b_cmd == 8'h80 && b_nadr == 2) begin
          b_page <= int'({F_IO_B[0], b_adr[1]});
          b_col  <= 0;
          b_pg_log.push_back({F_IO_B, b_adr[1], b_adr[0]});
        end
      end else if (b_cmd == 8'h80) begin
        if (b_col < PB && b_page < PAGES) memB[b_page*PB + b_col] <= F_IO_B;
        else b_spare <= b_spare + 1;
        b_col <= b_col + 1;
      end
    end
  end

  // Protocol monitor; violations are tallied and judged once at the end.
  int         proto_viol = 0, done_rises = 0;
  logic       rst_q = 1'b0, done_q = 1'b0, pa_wen_q = 1'b1, pb_wen_q = 1'b1;
  logic [7:0] io_a_w = 8'h00, io_b_w = 8'h00;

  always @(negedge clk) begin : protocol
    rst_q    <= rst;
    done_q   <= done;
    pa_wen_q <= F_WEN_A;
    pb_wen_q <= F_WEN_B;
    if (done && !done_q) done_rises <= done_rises + 1;
    if (!rst && !rst_q) begin
      if ((F_CLE_A && F_ALE_A) || (F_CLE_B && F_ALE_B) || (!F_REN_A && !F_WEN_A) || !F_REN_B) begin
        proto_viol <= proto_viol + 1;
        $display("[TB] protocol: strobe conflict at %0t", $time);
      end
      if (!F_REN_A && F_IO_A !== a_dout) begin
        proto_viol <= proto_viol + 1;
        $display("[TB] protocol: A bus contended during read at %0t", $time);
      end
      if (!F_WEN_A && pa_wen_q) io_a_w <= F_IO_A;
      else if (!pa_wen_q && F_IO_A !== io_a_w) begin
        proto_viol <= proto_viol + 1;
        $display("[TB] protocol: A IO moved inside write cycle at %0t", $time);
      end
      if (!F_WEN_B && pb_wen_q) io_b_w <= F_IO_B;
      else if (!pb_wen_q && F_IO_B !== io_b_w) begin
        proto_viol <= proto_viol + 1;
        $display("[TB] protocol: B IO moved inside write cycle at %0t", $time);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_ren_a"}, 32'(F_REN_A), 1);
    check_output({tag, "_wen_a"}, 32'(F_WEN_A), 1);
    check_output({tag, "_wen_b"}, 32'(F_WEN_B), 1);
    check_output({tag, "_ren_b"}, 32'(F_REN_B), 1);
    check_output({tag, "_cle_ale"}, 32'({F_CLE_A, F_ALE_A, F_CLE_B, F_ALE_B}), 0);
  endtask

  // Expected address bytes {page bit 8, page low byte, column 0}.
  function automatic logic [23:0] exp_addr(input int p);
    return {8'(p / 256), 8'(p % 256), 8'h00};
  endfunction

  initial begin : stimulus
    int rd_base, pg_base, errs, k;
    int pl[5] = '{0, 1, 255, 256, 257};

    for (int i = 0; i < N; i++) memA[i] = 8'($urandom);
    for (int i = 0; i < PB; i++) memA[i] = 8'(i * 37);

    #3 rst = 1'b1;
    @(posedge clk);
    #2 probe_en = 1'b1; probe_val = 8'hA5;
    #1 check_output("reset_io_a_released_a5", 32'(F_IO_A), 32'hA5);
    check_output("reset_io_b_released_a5", 32'(F_IO_B), 32'hA5);
    probe_val = 8'h5A;
    #1 check_output("reset_io_a_released_5a", 32'(F_IO_A), 32'h5A);
    check_output("reset_io_b_released_5a", 32'(F_IO_B), 32'h5A);
    probe_en = 1'b0;
    check_output("reset_done", 32'(done), 0);
    check_idle("reset");
    #4 rst = 1'b0;

    // Page 0 fully programmed once A is asked for page 1.
    for (int i = 0; i < 20000 && a_rd_log.size() < 2; i++) @(negedge clk);
    check_output("page0_reached", 32'(a_rd_log.size() >= 2), 1);
    for (int i = 0; i < PB; i++)
      check_output($sformatf("page0_byte%0d", i), 32'(memB[i]), 32'(memA[i]));

    // Abort in the middle of page 3's data transfer.
    for (int i = 0; i < 20000 && !(b_pg_log.size() == 4 && b_col >= 3 && b_col < PB); i++)
      @(negedge clk);
    check_output("page3_xfer_reached", 32'(b_pg_log.size() == 4 && b_col >= 3), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    check_output("midrst_done", 32'(done), 0);
    probe_en = 1'b1; probe_val = 8'hC3;
    #1 check_output("midrst_io_b_released", 32'(F_IO_B), 32'hC3);
    probe_en = 1'b0;
    rd_base = a_rd_log.size();
    pg_base = b_pg_log.size();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 60000 && !done; i++) @(negedge clk);
    check_output("done_after_copy", 32'(done), 1);
    repeat (5) @(negedge clk);
    check_output("done_sticky", 32'(done), 1);
    check_output("done_rose_once", 32'(done_rises), 1);
    check_idle("done");
    check_output("restart_issued_ffh_to_b", 32'(b_rst_cnt), 2);
    check_output("pages_read_after_restart", 32'(a_rd_log.size() - rd_base), 32'(PAGES));
    check_output("pages_programmed_after_restart", 32'(b_pg_log.size() - pg_base), 32'(PAGES));

    for (int j = 0; j < 5; j++) begin
      check_output($sformatf("rd_addr_page%0d", pl[j]),
                   (rd_base + pl[j] < a_rd_log.size()) ? 32'(a_rd_log[rd_base + pl[j]]) : 32'hFFFF_FFFF,
                   32'(exp_addr(pl[j])));
      check_output($sformatf("pg_addr_page%0d", pl[j]),
                   (pg_base + pl[j] < b_pg_log.size()) ? 32'(b_pg_log[pg_base + pl[j]]) : 32'hFFFF_FFFF,
                   32'(exp_addr(pl[j])));
    end

    check_output("page256_first_byte", 32'(memB[256*PB]), 32'(memA[256*PB]));
    for (int j = 0; j < 4; j++) begin
      k = int'($urandom_range(0, N - 1));
      check_output($sformatf("spot_byte%0d", k), 32'(memB[k]), 32'(memA[k]));
    end
    errs = 0;
    for (int i = 0; i < N; i++) if (memB[i] !== memA[i]) errs++;
    check_output("full_copy_byte_errors", 32'(errs), 0);
    check_output("spare_area_writes", 32'(b_spare), 0);
    check_output("protocol_violations", 32'(proto_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
